// File: rtl/hyperram_ctrl_if.sv
// Avalon-MM burst bus between a system master and the HyperRAM controller.
//   master modport: drives write/read/address/writedata/byteenable/burstcount,
//                   receives readdata/readdatavalid/waitrequest.
//   slave modport : the controller side (directions mirrored).
interface hyperram_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic              avm_write_i;
    logic              avm_read_i;
    logic [ADDR_W-1:0] avm_address_i;
    logic [15:0]       avm_writedata_i;
    logic [1:0]        avm_byteenable_i;
    logic [7:0]        avm_burstcount_i;
    logic [15:0]       avm_readdata_o;
    logic              avm_readdatavalid_o;
    logic              avm_waitrequest_o;

    modport master (
        output avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
               avm_byteenable_i, avm_burstcount_i,
        input  avm_readdata_o, avm_readdatavalid_o, avm_waitrequest_o
    );

    modport slave (
        input  avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
               avm_byteenable_i, avm_burstcount_i,
        output avm_readdata_o, avm_readdatavalid_o, avm_waitrequest_o
    );
endinterface

// File: rtl/hyperram_ctrl.sv
// HyperRAM command/transaction sequencer, x1 clock domain.
// Turns Avalon-MM bursts into CS#/CK/DQ/RWDS control words for the DDR I/O
// stage and returns captured read words as Avalon read data.
//   clk_x1_i, rstn_i      : system clock, async active-low reset
//   avm                   : Avalon-MM slave (hyperram_ctrl_if.slave)
//   read_error_o          : one-clock pulse when a read burst times out
//   ctrl_rstn_o           : device reset
//   ctrl_ck_ddr_o         : 2'b10 clock running, 2'b00 stopped
//   ctrl_csn_o            : chip select (active low)
//   ctrl_dq_ddr_in_i/ie_i : captured read word and its valid
//   ctrl_dq_ddr_out_o/oe_o: DQ word ([15:8] on first edge) and output enable
//   ctrl_rwds_ddr_out_o/oe_o : RWDS write mask and output enable
module hyperram_ctrl #(
    parameter int ADDR_W           = 22,
    parameter int INIT_RST_CYCLES  = 200,
    parameter int INIT_WAIT_CYCLES = 300,
    parameter int LATENCY_CYCLES   = 6,
    parameter int RECOVERY_CYCLES  = 3,
    parameter int READ_TIMEOUT     = 128
) (
    input  logic        clk_x1_i,
    input  logic        rstn_i,
    hyperram_ctrl_if.slave avm,
    output logic        read_error_o,
    output logic        ctrl_rstn_o,
    output logic [1:0]  ctrl_ck_ddr_o,
    output logic        ctrl_csn_o,
    input  logic [15:0] ctrl_dq_ddr_in_i,
    input  logic        ctrl_dq_ie_i,
    output logic [15:0] ctrl_dq_ddr_out_o,
    output logic        ctrl_dq_oe_o,
    output logic [1:0]  ctrl_rwds_ddr_out_o,
    output logic        ctrl_rwds_oe_o
);
    localparam int INIT_TOT = INIT_RST_CYCLES + INIT_WAIT_CYCLES;
    localparam int M1       = (INIT_TOT > READ_TIMEOUT) ? INIT_TOT : READ_TIMEOUT;
    localparam int M2       = (LATENCY_CYCLES > RECOVERY_CYCLES) ? LATENCY_CYCLES : RECOVERY_CYCLES;
    localparam int M3       = (M1 > M2) ? M1 : M2;
    localparam int CNT_MAX  = (M3 > 3) ? M3 : 3;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t RST_LAST  = cnt_t'(INIT_RST_CYCLES - 1);
    localparam cnt_t INIT_LAST = cnt_t'(INIT_TOT - 1);
    localparam cnt_t LAT_LAST  = cnt_t'(LATENCY_CYCLES - 1);
    localparam cnt_t REC_LAST  = cnt_t'(RECOVERY_CYCLES - 1);
    localparam cnt_t TO_LAST   = cnt_t'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CA, S_LAT, S_WRITE, S_READ, S_RECOV
    } state_t;

    state_t            state, state_n;
    cnt_t              cnt;
    logic              rstn_q, is_read_q, have_word_q, rdv_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q, readdata_q;
    logic [1:0]        be_q;
    logic [7:0]        acc_left_q;   // write words still to be taken from Avalon
    logic [7:0]        out_left_q;   // words still to be driven / received
    logic [47:0]       ca;
    logic [7:0]        bc;
    logic              start, accept;

    assign ca     = {is_read_q, 1'b0, 1'b1, 29'(addr_q[ADDR_W-1:3]), 13'd0, addr_q[2:0]};
    assign bc     = (avm.avm_burstcount_i == 8'd0) ? 8'd1 : avm.avm_burstcount_i;
    assign start  = (state == S_IDLE) && (avm.avm_read_i || avm.avm_write_i);
    assign accept = (state == S_WRITE) && avm.avm_write_i && (acc_left_q != 8'd0);

    always_ff @(posedge clk_x1_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_INIT;
        else         state <= state_n;
    end

    // Shared phase counter; cleared on every state change so it only ever
    // counts up to the terminal value of the current state.
    always_ff @(posedge clk_x1_i or negedge rstn_i) begin
        if (!rstn_i)                                 cnt <= '0;
        else if (state_n != state)                   cnt <= '0;
        else if (state == S_READ && ctrl_dq_ie_i)    cnt <= '0;
        else if (state inside {S_INIT, S_CA, S_LAT, S_READ, S_RECOV}) cnt <= cnt + cnt_t'(1);
    end

    always_ff @(posedge clk_x1_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rstn_q      <= 1'b0;
            is_read_q   <= 1'b0;
            have_word_q <= 1'b0;
            rdv_q       <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            readdata_q  <= '0;
            be_q        <= '0;
            acc_left_q  <= '0;
            out_left_q  <= '0;
        end else begin
            rdv_q <= 1'b0;
            err_q <= 1'b0;
            if (state == S_INIT && cnt == RST_LAST) rstn_q <= 1'b1;
            if (start) begin
                is_read_q   <= avm.avm_read_i;
                addr_q      <= avm.avm_address_i;
                out_left_q  <= bc;
                acc_left_q  <= bc - 8'd1;
                have_word_q <= 1'b1;
                if (!avm.avm_read_i) begin
                    wdata_q <= avm.avm_writedata_i;
                    be_q    <= avm.avm_byteenable_i;
                end
            end
            if (state == S_WRITE) begin
                // A word taken this clock is driven on the next one; no word
                // taken means the next clock is a CK-stopped stall.
                if (have_word_q) out_left_q <= out_left_q - 8'd1;
                have_word_q <= accept;
                if (accept) begin
                    wdata_q    <= avm.avm_writedata_i;
                    be_q       <= avm.avm_byteenable_i;
                    acc_left_q <= acc_left_q - 8'd1;
                end
            end
            if (state == S_READ) begin
                if (ctrl_dq_ie_i) begin
                    readdata_q <= ctrl_dq_ddr_in_i;
                    rdv_q      <= 1'b1;
                    out_left_q <= out_left_q - 8'd1;
                end else if (cnt == TO_LAST) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n                = state;
        ctrl_csn_o             = 1'b1;
        ctrl_ck_ddr_o          = 2'b00;
        ctrl_dq_oe_o           = 1'b0;
        ctrl_rwds_oe_o         = 1'b0;
        ctrl_dq_ddr_out_o      = '0;
        ctrl_rwds_ddr_out_o    = 2'b00;
        avm.avm_waitrequest_o  = 1'b1;
        case (state)
            S_INIT:  if (cnt == INIT_LAST) state_n = S_IDLE;
            S_IDLE: begin
                avm.avm_waitrequest_o = 1'b0;
                if (start) state_n = S_CA;
            end
            S_CA: begin
                ctrl_csn_o    = 1'b0;
                ctrl_ck_ddr_o = 2'b10;
                ctrl_dq_oe_o  = 1'b1;
                case (cnt)
                    cnt_t'(0): ctrl_dq_ddr_out_o = ca[47:32];
                    cnt_t'(1): ctrl_dq_ddr_out_o = ca[31:16];
                    default:   ctrl_dq_ddr_out_o = ca[15:0];
                endcase
                if (cnt == cnt_t'(2)) state_n = is_read_q ? S_READ : S_LAT;
            end
            S_LAT: begin
                ctrl_csn_o    = 1'b0;
                ctrl_ck_ddr_o = 2'b10;
                if (cnt == LAT_LAST) state_n = S_WRITE;
            end
            S_WRITE: begin
                // During a stall DQ/RWDS stay driven with the last word; the
                // stopped clock means the device sees no extra edge.
                ctrl_csn_o            = 1'b0;
                ctrl_dq_oe_o          = 1'b1;
                ctrl_rwds_oe_o        = 1'b1;
                ctrl_dq_ddr_out_o     = wdata_q;
                ctrl_rwds_ddr_out_o   = ~be_q;
                ctrl_ck_ddr_o         = have_word_q ? 2'b10 : 2'b00;
                avm.avm_waitrequest_o = (acc_left_q == 8'd0);
                if (have_word_q && out_left_q == 8'd1) state_n = S_RECOV;
            end
            S_READ: begin
                ctrl_csn_o    = 1'b0;
                ctrl_ck_ddr_o = 2'b10;
                if ((ctrl_dq_ie_i && out_left_q == 8'd1) || (!ctrl_dq_ie_i && cnt == TO_LAST))
                    state_n = S_RECOV;
            end
            S_RECOV: if (cnt == REC_LAST) state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    assign ctrl_rstn_o             = rstn_q;
    assign read_error_o            = err_q;
    assign avm.avm_readdata_o      = readdata_q;
    assign avm.avm_readdatavalid_o = rdv_q;
endmodule

// File: tb/tb_hyperram_ctrl.sv
module tb_hyperram_ctrl;
    localparam int ADDR_W = 22;
    localparam int IRST   = 200;
    localparam int IWAIT  = 300;
    localparam int LAT    = 6;
    localparam int REC    = 3;
    localparam int TO     = 128;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hyperram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    logic        read_error, c_rstn, c_csn, dq_oe, rwds_oe, ie;
    logic [1:0]  ck, rwds_out;
    logic [15:0] dq_out, dq_in;

    hyperram_ctrl #(
        .ADDR_W(ADDR_W), .INIT_RST_CYCLES(IRST), .INIT_WAIT_CYCLES(IWAIT),
        .LATENCY_CYCLES(LAT), .RECOVERY_CYCLES(REC), .READ_TIMEOUT(TO)
    ) dut (
        .clk_x1_i(clk), .rstn_i(rstn), .avm(bus.slave),
        .read_error_o(read_error), .ctrl_rstn_o(c_rstn), .ctrl_ck_ddr_o(ck),
        .ctrl_csn_o(c_csn), .ctrl_dq_ddr_in_i(dq_in), .ctrl_dq_ie_i(ie),
        .ctrl_dq_ddr_out_o(dq_out), .ctrl_dq_oe_o(dq_oe),
        .ctrl_rwds_ddr_out_o(rwds_out), .ctrl_rwds_oe_o(rwds_oe)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {bit rd; logic [31:0] addr; int n; bit tmo;} txn_t;
    txn_t        exp_txn_q[$];
    logic [17:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] dev_mem[int];
    logic [15:0] w_dat[256];
    logic [1:0]  w_be[256];
    bit          sb_off = 1'b0;
    bit          mute = 1'b0;

    function automatic logic [15:0] init_val(int a);
        return 16'(a) ^ 16'hC35A;
    endfunction
    function automatic logic [15:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction
    function automatic logic [15:0] dev_rd(int a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction
    function automatic logic [47:0] exp_ca(bit rd, logic [31:0] a);
        logic [47:0] c;
        c = '0;
        c[47] = rd;
        c[45] = 1'b1;
        c[44:16] = a[31:3];
        c[2:0] = a[2:0];
        return c;
    endfunction

    // ---------------- device model + bus monitor ----------------
    bit          in_txn, t_rd, ie_acc, tmo_end;
    int          ca_n, lat_n, data_n, stall_n, rd_n, hi_n, dev_idx;
    int          last_stall, last_data;
    logic [47:0] ca_acc, last_ca;
    logic [31:0] dev_addr;
    logic [15:0] mw;
    txn_t        t;

    always @(negedge clk) begin
        if (!rstn) begin
            in_txn = 1'b0; ca_n = 0; hi_n = 100; ie = 1'b0; ie_acc = 1'b0; dq_in = '0;
        end else begin
            // read-data scoreboard: a valid must follow each accepted ie by one clock
            if (bus.avm_readdatavalid_o || ie_acc) begin
                chk("rdv_timing", bus.avm_readdatavalid_o, ie_acc);
                if (bus.avm_readdatavalid_o) begin
                    if (exp_rd_q.size() == 0) chk("rdata_unexpected", exp_rd_q.size(), 1);
                    else chk("rdata", bus.avm_readdata_o, exp_rd_q.pop_front());
                end
            end
            ie_acc = 1'b0;
            tmo_end = 1'b0;
            if (!c_csn) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    chk("recovery_min", hi_n >= REC, 1'b1);
                    ca_n = 0; lat_n = 0; data_n = 0; stall_n = 0; rd_n = 0; dev_idx = 0;
                end
                ie = 1'b0;
                if (ca_n < 3) begin
                    chk("ca_phase", {ck, dq_oe, rwds_oe}, 4'b1010);
                    ca_acc = {ca_acc[31:0], dq_out};
                    ca_n++;
                    if (ca_n == 3) begin
                        t_rd = ca_acc[47];
                        dev_addr = 32'({ca_acc[44:16], ca_acc[2:0]});
                        last_ca = ca_acc;
                    end
                end else if (t_rd) begin
                    chk("rd_phase", {ck, dq_oe}, 3'b100);
                    rd_n++;
                    if (!mute && $urandom_range(0, 2) != 0) begin
                        ie = 1'b1;
                        dq_in = dev_rd(int'(dev_addr) + dev_idx);
                        dev_idx++;
                        ie_acc = 1'b1;
                    end
                end else if (!dq_oe) begin
                    chk("lat_ck", ck, 2'b10);
                    lat_n++;
                end else if (ck == 2'b10) begin
                    data_n++;
                    if (!sb_off) begin
                        if (data_n == 1) chk("latency", lat_n, LAT);
                        chk("rwds_oe", rwds_oe, 1'b1);
                        if (exp_wr_q.size() == 0) chk("wdata_unexpected", exp_wr_q.size(), 1);
                        else chk("wdata", {dq_out, rwds_out}, exp_wr_q.pop_front());
                        mw = dev_rd(int'(dev_addr) + dev_idx);
                        if (!rwds_out[1]) mw[15:8] = dq_out[15:8];
                        if (!rwds_out[0]) mw[7:0] = dq_out[7:0];
                        dev_mem[int'(dev_addr) + dev_idx] = mw;
                        dev_idx++;
                    end
                end else begin
                    chk("stall_ck", ck, 2'b00);
                    stall_n++;
                end
            end else begin
                if (in_txn) begin
                    in_txn = 1'b0;
                    hi_n = 0;
                    last_stall = stall_n;
                    last_data = data_n;
                    if (!sb_off) begin
                        if (exp_txn_q.size() == 0) chk("txn_unexpected", exp_txn_q.size(), 1);
                        else begin
                            t = exp_txn_q.pop_front();
                            chk("ca_words", last_ca, exp_ca(t.rd, t.addr));
                            if (t.rd && t.tmo) begin
                                chk("timeout_len", rd_n, TO);
                                chk("read_error", read_error, 1'b1);
                                tmo_end = 1'b1;
                            end else if (!t.rd) chk("wr_words", data_n, t.n);
                        end
                    end
                end
                hi_n++;
                chk("idle_outputs", {ck, dq_oe, rwds_oe}, 4'b0000);
                // stray captured words while deselected must be ignored
                ie = ($urandom_range(0, 3) == 0);
                dq_in = 16'hDEAD;
            end
            if (!tmo_end) chk("no_read_error", read_error, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int k = 0;
        while (bus.avm_waitrequest_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("waitrequest_timeout", bus.avm_waitrequest_o, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input int bc, input int gap_at, input int gap);
        int n = (bc == 0) ? 1 : bc;
        logic [15:0] m;
        exp_txn_q.push_back('{1'b0, a, n, 1'b0});
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({w_dat[i], ~w_be[i]});
            m = ref_rd(int'(a) + i);
            if (w_be[i][1]) m[15:8] = w_dat[i][15:8];
            if (w_be[i][0]) m[7:0] = w_dat[i][7:0];
            ref_mem[int'(a) + i] = m;
        end
        wait_ready();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i == gap_at) begin
                bus.avm_write_i = 1'b0;
                repeat (gap) @(negedge clk);
            end
            bus.avm_write_i = 1'b1;
            bus.avm_address_i = a[ADDR_W-1:0];
            bus.avm_burstcount_i = bc[7:0];
            bus.avm_writedata_i = w_dat[i];
            bus.avm_byteenable_i = w_be[i];
            wait_ready();
            @(negedge clk);
        end
        bus.avm_write_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int bc, input bit tmo);
        int n = (bc == 0) ? 1 : bc;
        exp_txn_q.push_back('{1'b1, a, n, tmo});
        if (!tmo) for (int i = 0; i < n; i++) exp_rd_q.push_back(ref_rd(int'(a) + i));
        wait_ready();
        mute = tmo;
        bus.avm_read_i = 1'b1;
        bus.avm_address_i = a[ADDR_W-1:0];
        bus.avm_burstcount_i = bc[7:0];
        @(negedge clk);
        bus.avm_read_i = 1'b0;
        if (tmo) begin
            @(negedge clk);
            wait_ready();
            mute = 1'b0;
        end
    endtask

    task automatic init_check();
        int rst_lo = -1;
        int wr_lo = -1;
        for (int k = 0; k < 700; k++) begin
            if (rst_lo < 0 && c_rstn) rst_lo = k;
            if (wr_lo < 0 && !bus.avm_waitrequest_o) wr_lo = k;
            if (wr_lo >= 0) break;
            @(negedge clk);
        end
        chk("rstn_low_clocks", rst_lo, IRST);
        chk("init_wait_clocks", wr_lo, IRST + IWAIT);
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) begin
            w_dat[i] = 16'($urandom);
            w_be[i] = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        logic [31:0] regions [4];
        logic [31:0] a;
        int n, k;
        regions[0] = 32'h0; regions[1] = 32'h0A5000;
        regions[2] = 32'h1FFF80; regions[3] = 32'h3FFE00;
        bus.avm_write_i = 1'b0; bus.avm_read_i = 1'b0; bus.avm_address_i = '0;
        bus.avm_writedata_i = '0; bus.avm_byteenable_i = '0; bus.avm_burstcount_i = '0;

        #3;
        chk("rst_outputs", {c_rstn, c_csn, ck, dq_oe, rwds_oe, rwds_out}, 8'b0100_0000);
        chk("rst_dq", dq_out, 16'h0);
        chk("rst_avm", {bus.avm_waitrequest_o, bus.avm_readdatavalid_o, read_error}, 3'b100);
        chk("rst_readdata", bus.avm_readdata_o, 16'h0);
        @(negedge clk);
        rstn = 1'b1;
        init_check();

        // single write, all bytes enabled
        w_dat[0] = 16'hABCD; w_be[0] = 2'b11;
        do_write(32'h012345, 1, -1, 0);
        wait_ready();
        chk("ca_single_write", last_ca, 48'h2000_2468_0005);

        // 4-word write, byte mask on word 2, master stalls before word 3
        rand_words(4);
        w_be[0] = 2'b11; w_be[1] = 2'b01; w_be[2] = 2'b11; w_be[3] = 2'b11;
        do_write(32'h000400, 4, 2, 2);
        wait_ready();
        chk("stall_seen", last_stall > 0, 1'b1);
        chk("data_clocks", last_data, 4);

        // burstcount 0 behaves as a single word
        rand_words(1);
        do_write(32'h000777, 0, -1, 0);

        // 3-word read from preset locations
        ref_mem[32'h10] = 16'h1111; ref_mem[32'h11] = 16'h2222; ref_mem[32'h12] = 16'h3333;
        dev_mem[32'h10] = 16'h1111; dev_mem[32'h11] = 16'h2222; dev_mem[32'h12] = 16'h3333;
        do_read(32'h10, 3, 1'b0);
        wait_ready();
        chk("ca_read_hi", last_ca[47:32], 16'hA000);

        do_read(32'h012345, 1, 1'b0);
        do_read(32'h000400, 4, 1'b0);
        do_read(32'h000200, 2, 1'b1);   // device never answers

        for (int it = 0; it < 40; it++) begin
            a = regions[$urandom_range(0, 3)] + 32'($urandom_range(0, 63));
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 0) begin
                rand_words((n == 0) ? 1 : n);
                do_write(a, n, $urandom_range(1, 6), $urandom_range(0, 3));
            end else do_read(a, n, 1'b0);
        end

        // reset in the middle of a write burst
        wait_ready();
        sb_off = 1'b1;
        bus.avm_write_i = 1'b1; bus.avm_address_i = 22'h3F0000;
        bus.avm_burstcount_i = 8'd8; bus.avm_writedata_i = 16'h5555; bus.avm_byteenable_i = 2'b11;
        @(negedge clk);
        k = 0;
        while (!rwds_oe && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_write_phase", rwds_oe, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_ctrl", {c_rstn, c_csn, ck, dq_oe, rwds_oe}, 6'b010000);
        chk("async_rst_wait", bus.avm_waitrequest_o, 1'b1);
        bus.avm_write_i = 1'b0;
        repeat (3) @(negedge clk);
        exp_txn_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
        sb_off = 1'b0;
        rstn = 1'b1;
        init_check();

        rand_words(2);
        do_write(32'h000020, 2, -1, 0);
        do_read(32'h000020, 2, 1'b0);
        wait_ready();
        repeat (4) @(negedge clk);
        chk("txn_drained", exp_txn_q.size(), 0);
        chk("wr_drained", exp_wr_q.size(), 0);
        chk("rd_drained", exp_rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hyperram_ctrl.md
Name: hyperram_ctrl

Overview:
- Command/transaction sequencer directly upstream of the HyperRAM I/O stage.
- Converts a 16-bit Avalon-MM burst interface into CS#/CK/DQ/RWDS DDR control words, and turns the I/O stage's captured read words back into Avalon read data.
- Runs on the x1 system clock and handles device reset/init, the command-address phase, fixed write latency, write/read bursts and CS# recovery.

Parameters:
- ADDR_W, 22, Avalon word-address width (≤ 32).
- INIT_RST_CYCLES, 200, clocks ctrl_rstn_o is held low after reset.
- INIT_WAIT_CYCLES, 300, clocks waited after ctrl_rstn_o rises before IDLE.
- LATENCY_CYCLES, 6, clocks of CK between CA end and the first write word.
- RECOVERY_CYCLES, 3, minimum CS#-high clocks between transactions.
- READ_TIMEOUT, 128, max clocks in READ without ctrl_dq_ie_i before abort.

Ports:
- clk_x1_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- avm_write_i  in  1  Avalon write.
- avm_read_i  in  1  Avalon read.
- avm_address_i  in  ADDR_W  word address.
- avm_writedata_i  in  16  write word.
- avm_byteenable_i  in  2  byte enables.
- avm_burstcount_i  in  8  words in burst (1..255).
- avm_readdata_o  out  16  read word.
- avm_readdatavalid_o  out  1  read word valid.
- avm_waitrequest_o  out  1  stall.
- read_error_o  out  1  one-clock pulse on read timeout.
- ctrl_rstn_o  out  1  device reset.
- ctrl_ck_ddr_o  out  2  CK pattern: 2'b10 running, 2'b00 stopped.
- ctrl_csn_o  out  1  chip select, active low.
- ctrl_dq_ddr_in_i  in  16  captured read word.
- ctrl_dq_ie_i  in  1  captured word valid.
- ctrl_dq_ddr_out_o  out  16  DQ out; [15:8] is the first edge.
- ctrl_dq_oe_o  out  1  DQ output enable.
- ctrl_rwds_ddr_out_o  out  2  RWDS out (write mask).
- ctrl_rwds_oe_o  out  1  RWDS output enable.

Behaviour:
- One clock (clk_x1_i). Reset is asynchronous, active-low (rstn_i).
- Reset values:
  - ctrl_rstn_o=0, ctrl_csn_o=1, ctrl_ck_ddr_o=00, ctrl_dq_oe_o=0, ctrl_rwds_oe_o=0.
  - ctrl_dq_ddr_out_o=0, ctrl_rwds_ddr_out_o=00.
  - avm_waitrequest_o=1, avm_readdatavalid_o=0, read_error_o=0, avm_readdata_o=0.
  - State INIT.
- Reset mid-transaction: outputs return to reset values immediately and INIT restarts.
- INIT:
  - ctrl_rstn_o=0 for INIT_RST_CYCLES, then 1.
  - Wait INIT_WAIT_CYCLES, then IDLE. No Avalon commands are accepted.
- IDLE:
  - waitrequest=0.
  - On read or write, latch the request and go CA. Read has priority if both are asserted.
  - Latched fields: address, burstcount, writedata/byteenable (write only).
  - burstcount=0 is treated as 1.
- CA (3 clocks):
  - csn=0, ck=10, dq_oe=1, waitrequest=1.
  - dq_out = CA[47:32], then CA[31:16], then CA[15:0].
  - CA[47]=read, CA[46]=0, CA[45]=1 (linear burst).
  - CA[44:16]=addr[ADDR_W-1:3] zero-extended; CA[15:3]=0; CA[2:0]=addr[2:0].
- After CA: write goes to LATENCY, read goes to READ.
- LATENCY:
  - LATENCY_CYCLES clocks, ck=10, dq_oe=0, csn=0, waitrequest=1. Then WRITE.
- WRITE:
  - Each clock with a word available: dq_oe=1, rwds_oe=1, dq_out=word, rwds_out=~byteenable, ck=10.
  - The first word comes from the latched command. Each later word is accepted when avm_write_i && !waitrequest; waitrequest=0 only while words remain.
  - No word available (master stall): ck=00, outputs held, no word counted.
  - After the last word: dq_oe=0, rwds_oe=0, go RECOVERY.
- READ:
  - ck=10, csn=0, dq_oe=0, waitrequest=1.
  - Each ctrl_dq_ie_i: avm_readdata_o=ctrl_dq_ddr_in_i, avm_readdatavalid_o=1 (registered, 1-clock latency), remaining count decrements. Count reaching 0 → RECOVERY.
  - Timeout counter resets on each ie pulse. Reaching READ_TIMEOUT pulses read_error_o and goes RECOVERY. No further readdatavalid is issued for that burst.
- RECOVERY:
  - csn=1, ck=00, all OE=0, waitrequest=1, for RECOVERY_CYCLES. Then IDLE.
  - ctrl_dq_ie_i arriving in RECOVERY/IDLE is ignored.
- Counters are sized to their parameters and must not wrap. Burst count is 8 bits.

Test Plan:
- Reset release → ctrl_rstn_o low exactly 200 clocks; waitrequest=1 until 500 clocks after reset, then 0.
- Single write, addr=0x012345, data=0xABCD, be=11 → CA words 0x2000/0x2468/0x0005; 6 latency clocks; one clock dq=0xABCD, rwds=00; csn high ≥3 clocks.
- 4-word write, be=01 on word 2, master idles 2 clocks before word 3 → word 2 has rwds=10; ck=00 during the stall; exactly 4 data clocks total.
- 3-word read, addr=0x000010; model returns 0x1111/0x2222/0x3333 → CA[47:32]=0xA000; three readdatavalid pulses in order, each one clock after ie; then RECOVERY.
- Read with no ie pulses → read_error_o pulses at clock 128 of READ; no readdatavalid; csn returns high.
- Assert rstn_i low mid-WRITE burst → csn=1, all OE=0 asynchronously; INIT sequence restarts.
